// File: rtl/arc_pkg.sv
// Shared types for the ALU arbiter: opcode encoding, lock FSM states and port count.
package arc_pkg;

    localparam int ARB_NPORTS = 2;

    typedef enum logic [3:0] {
        ALU_AND   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_ADD   = 4'd2,
        ALU_SLL   = 4'd3,
        ALU_SRL   = 4'd4,
        ALU_SEQ   = 4'd5,
        ALU_SUB   = 4'd6,
        ALU_SLT   = 4'd7,
        ALU_LUI   = 4'd8,
        ALU_JAL   = 4'd9,
        ALU_NOR   = 4'd12,
        ALU_XOR   = 4'd13,
        ALU_PASSA = 4'd14
    } alu_op_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } lock_state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant selector: lock owner, then starved port 1, then port 0, then port 1.
module alu_arb_pick
    import arc_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic [ARB_NPORTS-1:0] req,
    input  logic [3:0]            starve_cnt,
    input  lock_state_t           lock_state,
    output logic [ARB_NPORTS-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (lock_state)
            OWN0:    gnt[0] = req[0];
            OWN1:    gnt[1] = req[1];
            default: begin
                if (req[1] && (starve_cnt == 4'(STARVE_MAX)))
                    gnt[1] = 1'b1;
                else if (req[0])
                    gnt[0] = 1'b1;
                else if (req[1])
                    gnt[1] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single-cycle ALU with registered per-port results.
// Optional ownership locking is built when ALU_ARB_LOCK_EN is defined.
//
// state    | meaning
// UNLOCKED | normal priority arbitration
// OWN0     | port 0 owns the ALU, port 1 stalls
// OWN1     | port 1 owns the ALU, port 0 stalls
module alu_arbiter
    import arc_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_con_Req0,
    input  logic [3:0]  i_con_AluCtrl0,
    input  logic [31:0] i_data_A0,
    input  logic [31:0] i_data_B0,
    input  logic [4:0]  i_data_shamt0,
    input  logic        i_con_Lock0,
    output logic        o_con_Gnt0,
    output logic        o_con_Valid0,
    output logic [31:0] o_data_Res0,
    output logic        o_con_Zero0,
    input  logic        i_con_Req1,
    input  logic [3:0]  i_con_AluCtrl1,
    input  logic [31:0] i_data_A1,
    input  logic [31:0] i_data_B1,
    input  logic [4:0]  i_data_shamt1,
    input  logic        i_con_Lock1,
    output logic        o_con_Gnt1,
    output logic        o_con_Valid1,
    output logic [31:0] o_data_Res1,
    output logic        o_con_Zero1,
    output logic [3:0]  o_con_AluCtrl,
    output logic [31:0] o_data_A,
    output logic [31:0] o_data_B,
    output logic [4:0]  o_data_shamt,
    input  logic [31:0] i_data_AluRes,
    input  logic        i_con_Zero
);

    logic [ARB_NPORTS-1:0] req;
    logic [ARB_NPORTS-1:0] pick_gnt;
    logic [ARB_NPORTS-1:0] gnt;
    logic [3:0]            starve_cnt;
    lock_state_t           lock_state;

    assign req = {i_con_Req1, i_con_Req0};

    alu_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .req        (req),
        .starve_cnt (starve_cnt),
        .lock_state (lock_state),
        .gnt        (pick_gnt)
    );

    // Nothing is accepted in a reset cycle, so requesters keep their ops pending.
    assign gnt        = i_rst ? '0 : pick_gnt;
    assign o_con_Gnt0 = gnt[0];
    assign o_con_Gnt1 = gnt[1];

    always_comb begin
        o_con_AluCtrl = 4'(ALU_AND);
        o_data_A      = '0;
        o_data_B      = '0;
        o_data_shamt  = '0;
        if (gnt[0]) begin
            o_con_AluCtrl = i_con_AluCtrl0;
            o_data_A      = i_data_A0;
            o_data_B      = i_data_B0;
            o_data_shamt  = i_data_shamt0;
        end else if (gnt[1]) begin
            o_con_AluCtrl = i_con_AluCtrl1;
            o_data_A      = i_data_A1;
            o_data_B      = i_data_B1;
            o_data_shamt  = i_data_shamt1;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_state <= UNLOCKED;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (gnt[0] && i_con_Lock0)
                        lock_state <= OWN0;
                    else if (gnt[1] && i_con_Lock1)
                        lock_state <= OWN1;
                end
                OWN0:    if (gnt[0] && !i_con_Lock0) lock_state <= UNLOCKED;
                OWN1:    if (gnt[1] && !i_con_Lock1) lock_state <= UNLOCKED;
                default: lock_state <= UNLOCKED;
            endcase
        end
    end
`else
    logic lock_unused;
    assign lock_unused = i_con_Lock0 ^ i_con_Lock1;
    assign lock_state  = UNLOCKED;
`endif

    // The counter freezes while an owner holds the ALU so ownership does not count as starvation.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            starve_cnt <= '0;
        else if (lock_state != UNLOCKED)
            starve_cnt <= starve_cnt;
        else if (gnt[1] || !i_con_Req1)
            starve_cnt <= '0;
        else if (gnt[0] && (starve_cnt < 4'(STARVE_MAX)))
            starve_cnt <= starve_cnt + 4'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_con_Valid0 <= 1'b0;
            o_con_Valid1 <= 1'b0;
            o_data_Res0  <= '0;
            o_data_Res1  <= '0;
            o_con_Zero0  <= 1'b0;
            o_con_Zero1  <= 1'b0;
        end else begin
            o_con_Valid0 <= gnt[0];
            o_con_Valid1 <= gnt[1];
            if (gnt[0]) begin
                o_data_Res0 <= i_data_AluRes;
                o_con_Zero0 <= i_con_Zero;
            end
            if (gnt[1]) begin
                o_data_Res1 <= i_data_AluRes;
                o_con_Zero1 <= i_con_Zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU closes the loop, a grant model predicts
// grants and queues expected results that are popped when each Valid pulse appears.
module tb_alu_arbiter;
    import arc_pkg::*;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, lock0, lock1;
    logic [3:0]  ctrl0, ctrl1;
    logic [31:0] a0, b0, a1, b1;
    logic [4:0]  sh0, sh1;
    logic        gnt0, gnt1, valid0, valid1, zero0, zero1;
    logic [31:0] res0, res1;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [4:0]  alu_sh;
    logic        alu_zero;

    int checks = 0;
    int failures = 0;

    int          m_cnt = 0;
    int          m_lock = 0;
    logic [1:0]  m_valid = '0;
    logic [1:0]  g_obs;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    alu_arbiter #(.STARVE_MAX(SM)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_con_Req0(req0), .i_con_AluCtrl0(ctrl0), .i_data_A0(a0), .i_data_B0(b0),
        .i_data_shamt0(sh0), .i_con_Lock0(lock0), .o_con_Gnt0(gnt0), .o_con_Valid0(valid0),
        .o_data_Res0(res0), .o_con_Zero0(zero0),
        .i_con_Req1(req1), .i_con_AluCtrl1(ctrl1), .i_data_A1(a1), .i_data_B1(b1),
        .i_data_shamt1(sh1), .i_con_Lock1(lock1), .o_con_Gnt1(gnt1), .o_con_Valid1(valid1),
        .o_data_Res1(res1), .o_con_Zero1(zero1),
        .o_con_AluCtrl(alu_ctrl), .o_data_A(alu_a), .o_data_B(alu_b), .o_data_shamt(alu_sh),
        .i_data_AluRes(alu_res), .i_con_Zero(alu_zero)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return b << sh;
            4'd4:    return b >> sh;
            4'd5:    return {31'd0, a == b};
            4'd6:    return a - b;
            4'd7:    return {31'd0, $signed(a) < $signed(b)};
            4'd8:    return {b[15:0], 16'd0};
            4'd9:    return a + 32'd4;
            4'd12:   return ~(a | b);
            4'd13:   return a ^ b;
            4'd14:   return a;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_f(alu_ctrl, alu_a, alu_b, alu_sh);
        alu_zero = (alu_res == 32'd0);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input int p, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic lk);
        if (p == 0) begin
            req0 = 1'b1; ctrl0 = c; a0 = a; b0 = b; sh0 = sh; lock0 = lk;
        end else begin
            req1 = 1'b1; ctrl1 = c; a1 = a; b1 = b; sh1 = sh; lock1 = lk;
        end
    endtask

    // One clock: predict and check at the falling edge, then advance the model past the rising edge.
    task automatic step();
        logic [1:0]  eg;
        logic [31:0] r;
        logic [32:0] e;
        logic        s_req1, s_lock0, s_lock1, s_rst;
        @(negedge clk);
        s_req1 = req1; s_lock0 = lock0; s_lock1 = lock1; s_rst = rst;
        eg = '0;
        if (!s_rst) begin
            if (m_lock == 1)                 eg[0] = req0;
            else if (m_lock == 2)            eg[1] = req1;
            else if (req1 && m_cnt == SM)    eg[1] = 1'b1;
            else if (req0)                   eg[0] = 1'b1;
            else if (req1)                   eg[1] = 1'b1;
        end
        g_obs = {gnt1, gnt0};
        check_val("gnt0", 32'(gnt0), 32'(eg[0]));
        check_val("gnt1", 32'(gnt1), 32'(eg[1]));
        check_val("valid0", 32'(valid0), 32'(m_valid[0]));
        check_val("valid1", 32'(valid1), 32'(m_valid[1]));
        if (m_valid[0]) begin
            if (q0.size() == 0) check_val("q0_size", 32'(q0.size()), 32'd1);
            else begin
                e = q0.pop_front();
                check_val("res0", res0, e[31:0]);
                check_val("zero0", 32'(zero0), 32'(e[32]));
            end
        end
        if (m_valid[1]) begin
            if (q1.size() == 0) check_val("q1_size", 32'(q1.size()), 32'd1);
            else begin
                e = q1.pop_front();
                check_val("res1", res1, e[31:0]);
                check_val("zero1", 32'(zero1), 32'(e[32]));
            end
        end
        if (eg[0]) begin
            r = alu_f(ctrl0, a0, b0, sh0);
            q0.push_back({r == 32'd0, r});
        end
        if (eg[1]) begin
            r = alu_f(ctrl1, a1, b1, sh1);
            q1.push_back({r == 32'd0, r});
        end
        @(posedge clk);
        if (s_rst) begin
            m_valid = '0; m_cnt = 0; m_lock = 0;
            q0.delete(); q1.delete();
        end else begin
            m_valid = eg;
            if (m_lock != 0)                 m_cnt = m_cnt;
            else if (eg[1] || !s_req1)       m_cnt = 0;
            else if (eg[0] && m_cnt < SM)    m_cnt = m_cnt + 1;
`ifdef ALU_ARB_LOCK_EN
            if (m_lock == 0) begin
                if (eg[0] && s_lock0)        m_lock = 1;
                else if (eg[1] && s_lock1)   m_lock = 2;
            end else if (m_lock == 1) begin
                if (eg[0] && !s_lock0)       m_lock = 0;
            end else if (eg[1] && !s_lock1) begin
                m_lock = 0;
            end
`endif
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [9:0] pat;
        rst = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        ctrl0 = 0; ctrl1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; sh0 = 0; sh1 = 0;

        // Reset held two cycles with both ports requesting.
        set_op(0, 4'd2, 32'd3, 32'd4, 5'd0, 1'b0);
        set_op(1, 4'd13, 32'hFF, 32'h0F, 5'd0, 1'b0);
        step();
        step();
        check_val("rst_res0", res0, 32'd0);
        check_val("rst_res1", res1, 32'd0);
        check_val("rst_zero", {30'd0, zero1, zero0}, 32'd0);
        check_val("rst_valid", {30'd0, valid1, valid0}, 32'd0);
        req0 = 0; req1 = 0; rst = 1'b0;
        step();
        check_val("idle_ctrl", 32'(alu_ctrl), 32'd0);
        check_val("idle_a", alu_a | alu_b | 32'(alu_sh), 32'd0);

        // Single port-0 ADD 5+7.
        set_op(0, 4'd2, 32'd5, 32'd7, 5'd0, 1'b0);
        step();
        req0 = 0;
        step();
        check_val("add_res0", res0, 32'd12);
        step();

        // Port-1 SUB 9-9 sets the zero flag.
        set_op(1, 4'd6, 32'd9, 32'd9, 5'd0, 1'b0);
        step();
        req1 = 0;
        step();
        check_val("sub_zero1", 32'(zero1), 32'd1);
        step();

        // Continuous contention: port 1 every STARVE_MAX+1 cycles.
        set_op(0, 4'd1, 32'h00F0, 32'h000F, 5'd0, 1'b0);
        set_op(1, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            pat[i] = g_obs[1];
        end
        check_val("pattern", 32'(pat), 32'(10'b1000010000));
        req0 = 0; req1 = 0;
        step();
        step();

        // A few mixed ops from both ports.
        set_op(0, 4'd12, 32'h1234_0000, 32'h0000_5678, 5'd0, 1'b0);
        set_op(1, 4'd8, 32'd0, 32'h0000_ABCD, 5'd0, 1'b0);
        step();
        req0 = 0;
        step();
        req1 = 0;
        set_op(0, 4'd4, 32'd0, 32'h8000_0000, 5'd31, 1'b0);
        step();
        set_op(0, 4'd14, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0);
        step();
        req0 = 0;
        step();
        step();

`ifdef ALU_ARB_LOCK_EN
        // Port 1 takes ownership; port 0 stalls until port 1 releases.
        set_op(1, 4'd9, 32'h100, 32'd0, 5'd0, 1'b1);
        step();
        req1 = 0;
        set_op(0, 4'd2, 32'd1, 32'd1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        set_op(1, 4'd2, 32'h100, 32'h20, 5'd0, 1'b0);
        step();
        req1 = 0;
        step();
        check_val("lock_gnt0", 32'(g_obs[0]), 32'd1);
        req0 = 0;
        step();
        step();
`endif

        // Reset right after an accepted SLL loses the result; the held request is regranted.
        set_op(0, 4'd3, 32'd0, 32'd1, 5'd4, 1'b0);
        step();
        rst = 1'b1;
        step();
        check_val("mid_valid0", 32'(valid0), 32'd0);
        check_val("mid_res0", res0, 32'd0);
        rst = 1'b0;
        step();
        req0 = 0;
        step();
        check_val("reissue_res0", res0, 32'd16);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle `alu` between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. Each cycle it grants at most one requester and muxes that requester's operands and control onto the ALU. It registers the ALU result back to the granted port with a one-cycle valid pulse. Port 0 has priority, and a starvation counter guarantees port 1 forward progress.

## Interface
Parameters:
- `STARVE_MAX`, default 4: maximum consecutive port-0 grants while port 1 is waiting; legal range 1..15.

Ports (p = 0, 1):
- `i_clk` in 1: clock. One clock domain.
- `i_rst` in 1: synchronous, active-high reset.
- `i_con_Req{p}` in 1: operation request; held with its operands until granted.
- `i_con_AluCtrl{p}` in 4: ALU opcode. Same encoding as the ALU: 0 AND … 14 pass-A.
- `i_data_A{p}`, `i_data_B{p}` in 32: operands.
- `i_data_shamt{p}` in 5: shift amount.
- `i_con_Lock{p}` in 1: keep ownership of the ALU after this op (see Configuration).
- `o_con_Gnt{p}` out 1: combinational accept for this cycle.
- `o_con_Valid{p}` out 1: registered result valid, one-cycle pulse.
- `o_data_Res{p}` out 32: registered ALU result.
- `o_con_Zero{p}` out 1: registered ALU zero flag.
- `o_con_AluCtrl` out 4, `o_data_A` out 32, `o_data_B` out 32, `o_data_shamt` out 5: drive the ALU.
- `i_data_AluRes` in 32, `i_con_Zero` in 1: ALU outputs.

## Operation
- **Handshake.** A request is accepted in the cycle where both `Req` and `Gnt` are high. The requester may change its operands or drop `Req` on the next cycle. `Gnt` is never high without `Req`.
- **Grant order** (highest first):
  1. Lock owner, if locked. A non-owner is never granted.
  2. Port 1, if `i_con_Req1` is high and `starve_cnt == STARVE_MAX`.
  3. Port 0, if `i_con_Req0` is high.
  4. Port 1, if `i_con_Req1` is high.
- **Starvation counter** (`starve_cnt`, 4 bits, saturating at `STARVE_MAX`):
  - Increments when port 0 is granted while `i_con_Req1` is high.
  - Clears when port 1 is granted, or when `i_con_Req1` is low.
  - Holds while locked.
- **ALU drive.** The granted port's ctrl, A, B and shamt pass through combinationally. With no grant, the ALU is driven with ctrl=0 and A=B=shamt=0.
- **Response.** On the accepting edge, `i_data_AluRes` and `i_con_Zero` are captured into the granted port's `Res`/`Zero` registers, and its `Valid` register is set. `Valid` clears on the next edge unless there is a back-to-back grant to the same port. A port's `Res`/`Zero` hold their value until its next accepted op.
- **Reset state.** While `i_rst` is high:
  - Both `Gnt` are forced low.
  - On the edge: `Valid`/`Res`/`Zero` of both ports are cleared to 0, `starve_cnt` to 0, and the lock FSM to `UNLOCKED`.
  - An op presented in a reset cycle is not accepted; the requester keeps it pending.

## Timing
- Arbitration, mux and ALU form one combinational path in cycle N. The result is visible at `o_data_Res{p}` and `o_con_Valid{p}` in cycle N+1.
- Latency is 1 cycle; throughput is 1 op/cycle total across both ports.
- Simultaneous requests with no lock and `starve_cnt < STARVE_MAX`: port 0 is granted and port 1 waits.
- With both ports requesting continuously and no lock, port 1 is granted exactly once every `STARVE_MAX+1` cycles.
- Reset asserted mid-stream: a pending `Valid` is cleared on that edge and the result is lost. Requesters reissue after reset.

## Configuration
Macro: `ALU_ARB_LOCK_EN`.

**Defined:** lock FSM with states `UNLOCKED`, `OWN0`, `OWN1`.
- `UNLOCKED` → `OWN{p}` on an accepted op from port p with `i_con_Lock{p}`=1.
- `OWN{p}` → `UNLOCKED` on an accepted op from port p with `i_con_Lock{p}`=0.
- `OWN{p}` → `OWN{p}` otherwise, including cycles where the owner is idle. The other port stalls.

This supports multi-op sequences, e.g. jal link and target computed back-to-back.

**Undefined:**
- `i_con_Lock{p}` is ignored.
- There is no FSM state; the block is always `UNLOCKED`.
- Behaviour is otherwise identical.

## Structure
- Shared package `arc_pkg` holds:
  - `alu_op_t`, a 4-bit enum of the opcodes: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SEQ=5, SUB=6, SLT=7, LUI=8, JAL=9, NOR=12, XOR=13, PASSA=14.
  - `lock_state_t`.
  - `ARB_NPORTS=2`.
- One sub-module, `alu_arb_pick`: a combinational grant selector taking reqs, `starve_cnt` and lock state, and producing one-hot grants. The top holds the counter, FSM, mux and response registers.

## Test plan
- **Reset.** Hold `i_rst` 2 cycles with both Req=1 → Gnt0=Gnt1=0 throughout, and all Valid/Res/Zero=0 after the edge.
- **Single port-0 ADD.** A=5, B=7 → Gnt0=1 in cycle N; in N+1, Res0=12, Zero0=0, Valid0=1; Valid0=0 in N+2.
- **Port-1 SUB.** A=9, B=9 → Res1=0, Zero1=1, Valid1 pulse. Port 0 is idle and sees no Valid0.
- **Contention, STARVE_MAX=4.** Both Req held 10 cycles → grant pattern 0,0,0,0,1,0,0,0,0,1.
- **Lock (macro defined).** Port 1 requests with Lock=1 and is accepted, then port 0 requests continuously → Gnt0 stays 0 until port 1 issues an op with Lock=0. Port 0 is granted the cycle after that.
- **Reset mid-stream.** Reset on the edge after a port-0 SLL (B=1, shamt=4) is accepted → Valid0=0 and Res0=0, not 16; pending Req is granted in the first non-reset cycle.
